// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared widths, FSM states and step-to-index decode for the 2x2 matmul sequencer
package matmul_pkg;

  localparam int DW_DEF  = 4;
  localparam int OW_DEF  = 2 * DW_DEF;
  localparam int N_STEPS = 8;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  // Step k = {i, j, kk}: A is indexed [i][kk], B is indexed [kk][j].
  function automatic logic a_row(input logic [2:0] k);
    return k[2];
  endfunction

  function automatic logic a_col(input logic [2:0] k);
    return k[0];
  endfunction

  function automatic logic b_row(input logic [2:0] k);
    return k[0];
  endfunction

  function automatic logic b_col(input logic [2:0] k);
    return k[1];
  endfunction

  function automatic logic [1:0] c_idx(input logic [2:0] k);
    return k[2:1];
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// rtl/matmul_mac.sv - shared DWxDW multiplier with OW-bit accumulate, purely combinational
module matmul_mac #(
  parameter int DW = 4,
  parameter int OW = 8
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [OW-1:0] acc,
  input  logic          first,
  output logic [OW-1:0] result
);

  logic [2*DW-1:0] p;
  logic [OW-1:0]   p_ext;

  assign p      = a * b;
  assign p_ext  = OW'(p);
  // Carry out of the OW-bit sum is dropped to match the combinational reference.
  assign result = first ? p_ext : acc + p_ext;

endmodule

// File: rtl/matmul2x2_seq.sv
// rtl/matmul2x2_seq.sv - time-multiplexed 2x2 matrix multiplier, one MAC over eight steps
module matmul2x2_seq
  import matmul_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int OW = OW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4*DW-1:0] a_mat,
  input  logic [4*DW-1:0] b_mat,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [4*OW-1:0] c_mat,
  output logic          busy
);

  state_t          state_q, state_d;
  logic [2:0]      k_q;
  logic [OW-1:0]   acc_q;
  logic [4*DW-1:0] a_q, b_q;
  logic [4*OW-1:0] c_q;

  logic [1:0]      a_idx, b_idx;
  logic [DW-1:0]   a_el, b_el;
  logic [OW-1:0]   mac_result;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign c_mat     = c_q;

  assign a_idx = {a_row(k_q), a_col(k_q)};
  assign b_idx = {b_row(k_q), b_col(k_q)};
  assign a_el  = a_q[DW*a_idx +: DW];
  assign b_el  = b_q[DW*b_idx +: DW];

  matmul_mac #(.DW(DW), .OW(OW)) u_mac (
    .a      (a_el),
    .b      (b_el),
    .acc    (acc_q),
    .first  (~k_q[0]),
    .result (mac_result)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = CALC;
      CALC:    if (k_q == 3'(N_STEPS - 1)) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && in_valid) begin
        a_q <= a_mat;
        b_q <= b_mat;
      end
      if (state_q == CALC) begin
        // k wraps 7 -> 0 on the last step, leaving it ready for the next job.
        k_q <= k_q + 3'd1;
        if (k_q[0]) c_q[OW*c_idx(k_q) +: OW] <= mac_result;
        else        acc_q <= mac_result;
      end
    end
  end

endmodule
